// File: rtl/crosswalk_violation_judge_if.sv
// Pixel stream, frame strobe and alarm handshake between the video front end
// and the crosswalk violation judge.
interface crosswalk_violation_judge_if #(
    parameter int unsigned CNT_W = 17
);
    logic             enable;
    logic             pixel_valid;
    logic             motion_pixel;
    logic             car_detection_en;
    logic             human_detection_en;
    logic             v_finish;
    logic             alarm_ack;
    logic             alarm_valid;
    logic [1:0]       alarm_type;
    logic             violation_pulse;
    logic [CNT_W-1:0] frame_car_cnt;
    logic [CNT_W-1:0] frame_human_cnt;
    logic [7:0]       violation_total;
    logic [2:0]       state_dbg;

    modport slave (
        input  enable, pixel_valid, motion_pixel, car_detection_en,
               human_detection_en, v_finish, alarm_ack,
        output alarm_valid, alarm_type, violation_pulse, frame_car_cnt,
               frame_human_cnt, violation_total, state_dbg
    );

    modport master (
        output enable, pixel_valid, motion_pixel, car_detection_en,
               human_detection_en, v_finish, alarm_ack,
        input  alarm_valid, alarm_type, violation_pulse, frame_car_cnt,
               frame_human_cnt, violation_total, state_dbg
    );
endinterface

// File: rtl/crosswalk_violation_judge.sv
// Counts moving pixels inside the crosswalk window per frame and raises an
// acknowledged alarm once hits persist for FRAME_PERSIST consecutive frames.
module crosswalk_violation_judge #(
    parameter int unsigned PIX_THRESH     = 200,
    parameter int unsigned FRAME_PERSIST  = 3,
    parameter int unsigned HOLDOFF_FRAMES = 30,
    parameter int unsigned CNT_W          = 17
) (
    input logic                        clk,
    input logic                        reset,
    crosswalk_violation_judge_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MONITOR = 3'd1,
        CONFIRM = 3'd2,
        ALARM   = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       persist, persist_nxt;
    logic [1:0]       cand_type, cand_nxt;
    logic [7:0]       hold, hold_nxt;
    logic             alarm_valid, alarm_valid_nxt;
    logic [1:0]       alarm_type, alarm_type_nxt;
    logic             violation_pulse, pulse_nxt;
    logic [7:0]       violation_total, total_nxt;
    logic [CNT_W-1:0] car_cnt, human_cnt;
    logic [CNT_W-1:0] frame_car_cnt, frame_human_cnt;
    logic             enter_alarm;
    logic             car_px, human_px, cnt_clear;
    logic [1:0]       hit;

    // The end-of-frame strobe owns its cycle: a coincident pixel is dropped.
    assign car_px    = bus.pixel_valid & bus.motion_pixel & bus.car_detection_en & ~bus.v_finish;
    assign human_px  = bus.pixel_valid & bus.motion_pixel & bus.human_detection_en & ~bus.v_finish;
    assign cnt_clear = ~bus.enable | (state == IDLE) | bus.v_finish;
    assign hit       = {32'(human_cnt) >= PIX_THRESH, 32'(car_cnt) >= PIX_THRESH};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            car_cnt         <= '0;
            human_cnt       <= '0;
            frame_car_cnt   <= '0;
            frame_human_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (cnt_clear)
                car_cnt <= '0;
            else if (car_px && car_cnt != '1)
                car_cnt <= car_cnt + CNT_W'(1);
            if (cnt_clear)
                human_cnt <= '0;
            else if (human_px && human_cnt != '1)
                human_cnt <= human_cnt + CNT_W'(1);
            if (bus.v_finish && bus.enable) begin
                frame_car_cnt   <= car_cnt;
                frame_human_cnt <= human_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            persist         <= '0;
            cand_type       <= '0;
            hold            <= '0;
            alarm_valid     <= 1'b0;
            alarm_type      <= '0;
            violation_pulse <= 1'b0;
            violation_total <= '0;
        end else begin
            state           <= state_nxt;
            persist         <= persist_nxt;
            cand_type       <= cand_nxt;
            hold            <= hold_nxt;
            alarm_valid     <= alarm_valid_nxt;
            alarm_type      <= alarm_type_nxt;
            violation_pulse <= pulse_nxt;
            violation_total <= total_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches.
        state_nxt       = state;
        persist_nxt     = persist;
        cand_nxt        = cand_type;
        hold_nxt        = hold;
        alarm_valid_nxt = alarm_valid;
        alarm_type_nxt  = alarm_type;
        pulse_nxt       = 1'b0;
        total_nxt       = violation_total;
        enter_alarm     = 1'b0;
        if (!bus.enable) begin
            state_nxt       = IDLE;
            persist_nxt     = '0;
            cand_nxt        = '0;
            hold_nxt        = '0;
            alarm_valid_nxt = 1'b0;
            alarm_type_nxt  = '0;
        end else begin
            case (state)
                IDLE: state_nxt = MONITOR;
                MONITOR: begin
                    if (bus.v_finish && hit != 2'b00) begin
                        persist_nxt = 4'd1;
                        cand_nxt    = hit;
                        if (FRAME_PERSIST == 1) enter_alarm = 1'b1;
                        else                    state_nxt   = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (bus.v_finish) begin
                        if ((hit & cand_type) != 2'b00) begin
                            persist_nxt = persist + 4'd1;
                            cand_nxt    = cand_type | hit;
                            if (persist_nxt == 4'(FRAME_PERSIST)) enter_alarm = 1'b1;
                        end else begin
                            persist_nxt = '0;
                            cand_nxt    = '0;
                            state_nxt   = MONITOR;
                        end
                    end
                end
                ALARM: begin
                    if (bus.alarm_ack) begin
                        alarm_valid_nxt = 1'b0;
                        alarm_type_nxt  = '0;
                        persist_nxt     = '0;
                        cand_nxt        = '0;
                        hold_nxt        = 8'(HOLDOFF_FRAMES);
                        state_nxt       = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (bus.v_finish) begin
                        if (hold == 8'd1) begin
                            hold_nxt  = '0;
                            state_nxt = MONITOR;
                        end else begin
                            hold_nxt = hold - 8'd1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (enter_alarm) begin
                state_nxt       = ALARM;
                alarm_valid_nxt = 1'b1;
                alarm_type_nxt  = cand_nxt;
                pulse_nxt       = 1'b1;
                if (violation_total != 8'hFF) total_nxt = violation_total + 8'd1;
            end
        end
    end

    assign bus.alarm_valid     = alarm_valid;
    assign bus.alarm_type      = alarm_type;
    assign bus.violation_pulse = violation_pulse;
    assign bus.frame_car_cnt   = frame_car_cnt;
    assign bus.frame_human_cnt = frame_human_cnt;
    assign bus.violation_total = violation_total;
    assign bus.state_dbg       = state;
endmodule

// File: tb/tb_crosswalk_violation_judge.sv
// Directed frames for the crosswalk violation judge; a monitor checks every
// frame snapshot and alarm against a queue filled by the stimulus.
module tb_crosswalk_violation_judge;
    // A narrow counter keeps the saturation frame short.
    localparam int CNT_W = 10;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int S_IDLE = 0, S_MON = 1, S_CONF = 2, S_ALARM = 3, S_HOLD = 4;

    typedef struct { int car; int hum; int st; int p; } frame_exp_t;
    typedef struct { int typ; int total; } alarm_exp_t;

    logic clk;
    logic reset;
    int   total_checks = 0;
    int   bad = 0;
    frame_exp_t frame_q[$];
    alarm_exp_t alarm_q[$];

    crosswalk_violation_judge_if #(.CNT_W(CNT_W)) bus ();

    crosswalk_violation_judge #(
        .PIX_THRESH(200), .FRAME_PERSIST(3), .HOLDOFF_FRAMES(30), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic mo, input logic ce, input logic he);
        bus.pixel_valid        = pv;
        bus.motion_pixel       = mo;
        bus.car_detection_en   = ce;
        bus.human_detection_en = he;
    endtask

    task automatic frame(input int car_n, input int hum_n, input int exp_st,
                         input int exp_p, input bit ack_at_vf);
        frame_exp_t fe;
        for (int i = 0; i < car_n; i++) begin
            drive(1, 1, 1, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 1);
            tick();
        end
        for (int i = 0; i < hum_n; i++) begin
            drive(1, 1, 0, 1);
            tick();
        end
        fe.car = (car_n > MAXC) ? MAXC : car_n;
        fe.hum = (hum_n > MAXC) ? MAXC : hum_n;
        fe.st  = exp_st;
        fe.p   = exp_p;
        frame_q.push_back(fe);
        drive(1, 1, 1, 1);
        bus.v_finish  = 1'b1;
        bus.alarm_ack = ack_at_vf;
        tick();
        drive(0, 0, 0, 0);
        bus.v_finish  = 1'b0;
        bus.alarm_ack = 1'b0;
        tick();
    endtask

    task automatic expect_alarm(input int typ, input int tot);
        alarm_exp_t ae;
        ae.typ   = typ;
        ae.total = tot;
        alarm_q.push_back(ae);
    endtask

    // Monitor: pops an expectation whenever the DUT shows a snapshot or alarm.
    bit vf_pending = 1'b0;
    bit prev_pulse = 1'b0;
    always @(negedge clk) begin
        frame_exp_t fe;
        alarm_exp_t ae;
        if (!reset) begin
            vf_pending = 1'b0;
            prev_pulse = 1'b0;
        end else begin
            if (vf_pending) begin
                if (frame_q.size() == 0) begin
                    check("unexpected_frame", frame_q.size(), 1);
                end else begin
                    fe = frame_q.pop_front();
                    check("frame_car_cnt", bus.frame_car_cnt, fe.car);
                    check("frame_human_cnt", bus.frame_human_cnt, fe.hum);
                    check("frame_state", bus.state_dbg, fe.st);
                    check("frame_persist", dut.persist, fe.p);
                end
            end
            if (bus.violation_pulse) begin
                check("pulse_width", prev_pulse, 0);
                if (alarm_q.size() == 0) begin
                    check("unexpected_alarm", alarm_q.size(), 1);
                end else begin
                    ae = alarm_q.pop_front();
                    check("alarm_valid_rise", bus.alarm_valid, 1);
                    check("alarm_type", bus.alarm_type, ae.typ);
                    check("violation_total", bus.violation_total, ae.total);
                end
            end
            prev_pulse = bus.violation_pulse;
            vf_pending = bus.v_finish && bus.enable;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stable;
        reset = 1'b1;
        bus.enable    = 1'b0;
        bus.v_finish  = 1'b0;
        bus.alarm_ack = 1'b0;
        drive(0, 0, 0, 0);
        #1 reset = 1'b0;
        #1;
        check("rst_state", bus.state_dbg, S_IDLE);
        check("rst_alarm_valid", bus.alarm_valid, 0);
        check("rst_total", bus.violation_total, 0);
        check("rst_frame_car", bus.frame_car_cnt, 0);
        check("rst_pulse", bus.violation_pulse, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("idle_while_disabled", bus.state_dbg, S_IDLE);
        bus.enable = 1'b1;
        tick();
        check("idle_to_monitor", bus.state_dbg, S_MON);

        // Three car frames raise a car alarm.
        expect_alarm(1, 1);
        frame(250, 0, S_CONF, 1, 0);
        frame(250, 0, S_CONF, 2, 0);
        frame(250, 0, S_ALARM, 3, 0);
        check("alarm_held_valid", bus.alarm_valid, 1);
        check("alarm_held_type", bus.alarm_type, 1);
        check("pulse_single", bus.violation_pulse, 0);
        stable = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.alarm_valid !== 1'b1 || bus.alarm_type !== 2'b01 ||
                bus.violation_pulse !== 1'b0 || bus.state_dbg !== 3'(S_ALARM))
                stable = 1'b0;
        end
        check("alarm_stable_1000", stable, 1);
        frame(250, 0, S_ALARM, 3, 0);
        frame(250, 0, S_HOLD, 0, 1);
        check("ack_drops_valid", bus.alarm_valid, 0);
        check("ack_clears_type", bus.alarm_type, 0);
        check("ack_total_kept", bus.violation_total, 1);
        for (int i = 1; i <= 30; i++)
            frame(250, 0, (i == 30) ? S_MON : S_HOLD, 0, i == 5);

        // Dip below threshold breaks persistence; 200 is exactly a hit.
        frame(250, 0, S_CONF, 1, 0);
        frame(250, 0, S_CONF, 2, 0);
        frame(199, 0, S_MON, 0, 0);
        frame(250, 0, S_CONF, 1, 0);
        frame(200, 0, S_CONF, 2, 0);
        frame(0, 0, S_MON, 0, 0);

        // Type switch breaks confirmation, human run then alarms.
        expect_alarm(2, 2);
        frame(250, 0, S_CONF, 1, 0);
        frame(0, 250, S_MON, 0, 0);
        frame(0, 250, S_CONF, 1, 0);
        frame(0, 250, S_CONF, 2, 0);
        frame(0, 250, S_ALARM, 3, 0);
        bus.enable    = 1'b0;
        bus.alarm_ack = 1'b1;
        tick();
        bus.alarm_ack = 1'b0;
        check("disable_ack_state", bus.state_dbg, S_IDLE);
        check("disable_ack_valid", bus.alarm_valid, 0);
        check("disable_ack_total", bus.violation_total, 2);
        check("disable_keeps_frame", bus.frame_human_cnt, 250);

        // Saturation, then enable dropped mid-CONFIRM.
        bus.enable = 1'b1;
        tick();
        frame(MAXC + 6, 3, S_CONF, 1, 0);
        for (int i = 0; i < 50; i++) begin
            drive(1, 1, 1, 0);
            tick();
        end
        bus.enable = 1'b0;
        tick();
        drive(0, 0, 0, 0);
        check("drop_state", bus.state_dbg, S_IDLE);
        check("drop_persist", dut.persist, 0);
        check("drop_cand", dut.cand_type, 0);
        check("drop_car_cnt", dut.car_cnt, 0);
        check("drop_keeps_frame", bus.frame_car_cnt, MAXC);

        // Both types in one frame give a combined alarm type.
        bus.enable = 1'b1;
        tick();
        expect_alarm(3, 3);
        frame(250, 250, S_CONF, 1, 0);
        frame(250, 0, S_CONF, 2, 0);
        frame(0, 250, S_ALARM, 3, 0);
        check("dual_type", bus.alarm_type, 3);

        // Asynchronous reset in ALARM, checked between edges.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", bus.alarm_valid, 0);
        check("async_rst_total", bus.violation_total, 0);
        check("async_rst_state", bus.state_dbg, S_IDLE);
        check("async_rst_frame", bus.frame_car_cnt, 0);
        #20;
        check("frames_left", frame_q.size(), 0);
        check("alarms_left", alarm_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total_checks, bad);
        $finish;
    end
endmodule
